// File: rtl/spi_master_cfg.sv
// spi_master_cfg
//   Runtime-configurable SPI master. It supports all four CPOL/CPHA modes,
//   MSB- or LSB-first bit order, a programmable SCK half-period and
//   multi-word bursts that keep chip select asserted between words.
//
// Ports
//   clk, rst         system clock, asynchronous active-high reset
//   cfg_cpol         SCK idle level
//   cfg_cpha         0: sample on the leading edge, 1: sample on the trailing edge
//   cfg_lsb_first    1: LSB is shifted first (transmit and receive)
//   cfg_div          SCK half-period H = cfg_div + 1 clk cycles
//   cs_sel           target slave index; values >= NUM_CS select no slave
//   cs_hold          keep CS asserted after this word (burst)
//   tx_valid/ready   word handshake; tx_data is the word to send
//   rx_valid         one-cycle pulse; rx_data holds the received word until the next pulse
//   busy             high whenever the FSM is not IDLE
//   sck, mosi, miso  SPI pins
//   cs_n             active-low chip selects
module spi_master_cfg #(
  parameter  int DATA_W = 8,
  parameter  int NUM_CS = 4,
  parameter  int DIV_W  = 16,
  localparam int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_cpol,
  input  logic              cfg_cpha,
  input  logic              cfg_lsb_first,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              cs_hold,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              sck,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_CS-1:0] cs_n
);

  localparam int EDGES = 2 * DATA_W;
  localparam int EW    = $clog2(EDGES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_XFER,
    S_TRAIL,
    S_GAP,
    S_HELD
  } state_t;

  state_t state, state_nxt;

  logic [DIV_W-1:0]  cnt;
  logic [DIV_W-1:0]  div_q;
  logic [EW-1:0]     edge_cnt;
  logic              cpol_q, cpha_q, lsb_q, hold_q;
  logic [CS_W-1:0]   sel_q;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] rx_sh;

  logic          accept;
  logic          tick;
  logic          sck_edge;
  logic [EW-1:0] edge_num;
  logic          lead_edge;
  logic          do_sample;
  logic          do_shift;
  logic          frame_done;
  logic          acc_cpha;
  logic          acc_lsb;

  // Bit that goes out next from a word, honouring the bit order.
  function automatic logic first_bit(input logic [DATA_W-1:0] d, input logic lsb);
    first_bit = lsb ? d[0] : d[DATA_W-1];
  endfunction

  // Word after its outgoing bit has been consumed.
  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] d, input logic lsb);
    shift_out = lsb ? (d >> 1) : (d << 1);
  endfunction

  // Active-low one-hot select; out-of-range indices assert nothing.
  function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
    cs_decode = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (sel == CS_W'(i)) cs_decode[i] = 1'b0;
    end
  endfunction

  assign tx_ready = (state == S_IDLE) || (state == S_HELD);
  assign busy     = (state != S_IDLE);

  always_comb begin
    accept     = tx_valid && tx_ready;
    tick       = (cnt == div_q);
    sck_edge   = tick && ((state == S_LEAD) || (state == S_XFER));
    edge_num   = (state == S_LEAD) ? EW'(1) : (edge_cnt + EW'(1));
    lead_edge  = edge_num[0];
    do_sample  = sck_edge && (cpha_q ? !lead_edge : lead_edge);
    // In CPHA=0 the first bit is already on mosi before edge 1, so the
    // trailing edges shift and the final trailing edge has nothing left.
    do_shift   = sck_edge && (cpha_q ? lead_edge
                                     : (!lead_edge && (edge_num != EW'(EDGES))));
    frame_done = (state == S_TRAIL) && tick;
    // A burst continuation reuses the mode latched by the first word.
    acc_cpha   = (state == S_HELD) ? cpha_q : cfg_cpha;
    acc_lsb    = (state == S_HELD) ? lsb_q  : cfg_lsb_first;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_LEAD;
      S_LEAD:  if (tick) state_nxt = S_XFER;
      S_XFER:  if (sck_edge && (edge_num == EW'(EDGES))) state_nxt = S_TRAIL;
      S_TRAIL: if (tick) state_nxt = hold_q ? S_HELD : S_GAP;
      S_GAP:   if (tick) state_nxt = S_IDLE;
      S_HELD:  if (accept) state_nxt = S_LEAD;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      div_q    <= '0;
      edge_cnt <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      lsb_q    <= 1'b0;
      hold_q   <= 1'b0;
      sel_q    <= '0;
      sck      <= 1'b0;
      mosi     <= 1'b0;
      cs_n     <= '1;
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else begin
      rx_valid <= frame_done;
      if (frame_done) rx_data <= rx_sh;

      // Half-period timer runs only while a frame or the gap is in progress.
      if ((state == S_IDLE) || (state == S_HELD) || tick) cnt <= '0;
      else                                                 cnt <= cnt + DIV_W'(1);

      if (accept)        edge_cnt <= '0;
      else if (sck_edge) edge_cnt <= edge_num;

      case (state)
        S_IDLE: begin
          sck  <= cfg_cpol;
          mosi <= 1'b0;
          cs_n <= '1;
          if (accept) begin
            cpol_q <= cfg_cpol;
            cpha_q <= cfg_cpha;
            lsb_q  <= cfg_lsb_first;
            div_q  <= cfg_div;
            sel_q  <= cs_sel;
            hold_q <= cs_hold;
            cs_n   <= cs_decode(cs_sel);
            if (!cfg_cpha) mosi <= first_bit(tx_data, cfg_lsb_first);
          end
        end
        S_HELD: begin
          sck <= cpol_q;
          if (accept) begin
            hold_q <= cs_hold;
            if (!cpha_q) mosi <= first_bit(tx_data, lsb_q);
          end
        end
        S_TRAIL: begin
          if (tick && !hold_q) cs_n <= '1;
        end
        default: ;
      endcase

      if (sck_edge) sck  <= ~sck;
      if (do_shift) mosi <= first_bit(tx_sh, lsb_q);
    end
  end

  // Shift registers carry pure data and need no reset.
  always_ff @(posedge clk) begin
    if (accept)        tx_sh <= acc_cpha ? tx_data : shift_out(tx_data, acc_lsb);
    else if (do_shift) tx_sh <= shift_out(tx_sh, lsb_q);

    if (do_sample) rx_sh <= lsb_q ? {miso, rx_sh[DATA_W-1:1]} : {rx_sh[DATA_W-2:0], miso};
  end

endmodule

// File: tb/tb_spi_master_cfg.sv
// Testbench for spi_master_cfg (DATA_W=8, NUM_CS=5 so that cs_sel=5 is out of range).
// A scoreboard queue receives the expected rx word, the transmitted word and the
// expected rx_valid cycle at every accept; a monitor pops and compares on rx_valid.
module tb_spi_master_cfg;
  localparam int DW   = 8;
  localparam int NCS  = 5;
  localparam int DIVW = 16;
  localparam int CSW  = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            cfg_cpol, cfg_cpha, cfg_lsb_first;
  logic [DIVW-1:0] cfg_div;
  logic [CSW-1:0]  cs_sel;
  logic            cs_hold;
  logic            tx_valid;
  logic            tx_ready;
  logic [DW-1:0]   tx_data;
  logic            rx_valid;
  logic [DW-1:0]   rx_data;
  logic            busy;
  logic            sck, mosi, miso;
  logic [NCS-1:0]  cs_n;

  spi_master_cfg #(.DATA_W(DW), .NUM_CS(NCS), .DIV_W(DIVW)) dut (
    .clk(clk), .rst(rst),
    .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha), .cfg_lsb_first(cfg_lsb_first),
    .cfg_div(cfg_div), .cs_sel(cs_sel), .cs_hold(cs_hold),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy),
    .sck(sck), .mosi(mosi), .miso(miso), .cs_n(cs_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] rx;
    logic [DW-1:0] tx;
    int            at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int tests_run    = 0;
  int tests_failed = 0;
  int rx_count     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // ---------------- slave model ----------------
  logic [DW-1:0] slave_word = '0;
  logic [DW-1:0] slave_rx   = '0;
  logic          loopback   = 1'b0;
  logic          sb_cpha    = 1'b0;
  logic          sb_lsb     = 1'b0;
  int            tr_count   = 0;
  int            tr_base    = 0;

  // Every SCK transition is one edge; the slave captures mosi on sampling edges.
  always @(sck) begin
    int e, b;
    logic [2:0] p;
    e = ((tr_count - tr_base) % (2 * DW)) + 1;
    if (sb_cpha ? (e % 2 == 0) : (e % 2 == 1)) begin
      b = (e - 1) / 2;
      p = 3'(sb_lsb ? b : DW - 1 - b);
      slave_rx[p] = mosi;
    end
    tr_count++;
  end

  // The slave presents bit j before the edge on which the master samples it.
  always_comb begin
    int t, b;
    logic [2:0] p;
    t = (tr_count - tr_base) % (2 * DW);
    b = sb_cpha ? ((t == 0) ? 0 : (t - 1) / 2) : t / 2;
    p = 3'(sb_lsb ? b : DW - 1 - b);
    miso = loopback ? mosi : slave_word[p];
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst && rx_valid) begin
      rx_count++;
      if (sb.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_rx: got rx_valid with rx_data %0h, required no pulse", rx_data);
      end else begin
        mon_e = sb.pop_front();
        check("rx_data", 32'(rx_data), 32'(mon_e.rx));
        check("rx_cycle", cyc, mon_e.at);
        check("mosi_word", 32'(slave_rx), 32'(mon_e.tx));
      end
    end
  end

  // Burst window: count cycles in which cs_n[2] is high.
  int win_lo = 32'h7fff_ffff;
  int win_hi = 0;
  int cs2_high = 0;
  always @(negedge clk) begin
    if (cyc >= win_lo && cyc <= win_hi && cs_n[2]) cs2_high++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_cfg(input logic cpol, input logic cpha, input logic lsb,
                         input logic [DIVW-1:0] div, input logic [CSW-1:0] sel,
                         input logic lb, input logic [DW-1:0] sw);
    cfg_cpol = cpol; cfg_cpha = cpha; cfg_lsb_first = lsb;
    cfg_div = div; cs_sel = sel;
    sb_cpha = cpha; sb_lsb = lsb; loopback = lb; slave_word = sw;
    repeat (2) @(negedge clk);
    tr_base = tr_count;
  endtask

  // Called at a negedge; returns at the negedge of cycle T+1 with T the accept cycle.
  task automatic send(input logic [DW-1:0] d, input logic hold, input logic [DW-1:0] exp_rx,
                      input int h, output int t_acc);
    int n;
    exp_t e;
    n = 0;
    tx_data = d; cs_hold = hold; tx_valid = 1'b1;
    while (!tx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    t_acc = cyc;
    if (!tx_ready) begin
      tests_run++;
      tests_failed++;
      $display("FAIL accept_timeout: tx_ready stayed %0b, required 1", tx_ready);
      tx_valid = 1'b0;
      return;
    end
    e.rx = exp_rx; e.tx = d; e.at = cyc + 1 + (2 * DW + 1) * h;
    sb.push_back(e);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(busy), 32'(0));
    @(negedge clk);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Waits for rx_valid; returns at that negedge. ok=0 if the bound expired.
  task automatic wait_rx(output bit ok);
    int n;
    n = 0;
    ok = 1'b0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (rx_valid) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  // Table for the div=0 four-mode sweep.
  logic [DW-1:0] m_tx [4] = '{8'hC3, 8'h5A, 8'h0F, 8'h96};
  logic [DW-1:0] m_sl [4] = '{8'h6E, 8'hB1, 8'h24, 8'hF0};

  initial begin
    int  t, t3, cnt_snap;
    bit  ok;
    rst = 1'b1;
    cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_lsb_first = 1'b0;
    cfg_div = '0; cs_sel = '0; cs_hold = 1'b0;
    tx_valid = 1'b0; tx_data = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_tx_ready", 32'(tx_ready), 32'(1));
    check("rst_rx_valid", 32'(rx_valid), 32'(0));
    check("rst_rx_data",  32'(rx_data),  32'(0));
    check("rst_busy",     32'(busy),     32'(0));
    check("rst_sck",      32'(sck),      32'(0));
    check("rst_mosi",     32'(mosi),     32'(0));
    check("rst_cs_n",     32'(cs_n),     32'h1F);
    rst = 1'b0;
    @(negedge clk);

    // Mode 0, MSB-first, H=2, loopback; config wiggled mid-frame
    set_cfg(1'b0, 1'b0, 1'b0, 16'd1, 3'd0, 1'b1, 8'h00);
    send(8'hA5, 1'b0, 8'hA5, 2, t);
    cfg_div = 16'd5; cs_sel = 3'd3; cfg_cpha = 1'b1; cfg_lsb_first = 1'b1;
    check("m0_cs_first", 32'(cs_n), 32'h1E);
    check("m0_sck_lead", 32'(sck), 32'(0));
    @(negedge clk);
    check("m0_sck_pre_edge", 32'(sck), 32'(0));
    @(negedge clk);
    check("m0_sck_edge1", 32'(sck), 32'(1));
    wait_cyc(t + 34);
    check("m0_cs_last", 32'(cs_n), 32'h1E);
    @(negedge clk);
    check("m0_cs_release", 32'(cs_n), 32'h1F);
    wait_idle();

    // Mode 3, LSB-first, slave returns 0x81
    set_cfg(1'b1, 1'b1, 1'b1, 16'd1, 3'd0, 1'b0, 8'h81);
    check("m3_sck_idle", 32'(sck), 32'(1));
    send(8'h3C, 1'b0, 8'h81, 2, t);
    check("m3_sck_lead", 32'(sck), 32'(1));
    wait_idle();

    // Burst of three words on cs_sel=2
    set_cfg(1'b0, 1'b0, 1'b0, 16'd1, 3'd2, 1'b0, 8'h5A);
    cs2_high = 0;
    win_hi = 32'h7fff_ffff;
    send(8'h11, 1'b1, 8'h5A, 2, t);
    win_lo = t + 1;
    cfg_cpol = 1'b1; cs_sel = 3'd0;
    send(8'h22, 1'b1, 8'h5A, 2, t);
    check("burst_held_sck", 32'(sck), 32'(0));
    send(8'h33, 1'b0, 8'h5A, 2, t3);
    win_hi = t3 + 34;
    wait_rx(ok);
    check("burst_rx3_seen", 32'(ok), 32'(1));
    check("burst_cs_release", 32'(cs_n), 32'h1F);
    check("burst_gap_ready0", 32'(tx_ready), 32'(0));
    @(negedge clk);
    check("burst_gap_ready1", 32'(tx_ready), 32'(0));
    @(negedge clk);
    check("burst_idle_ready", 32'(tx_ready), 32'(1));
    check("burst_cs2_low", cs2_high, 0);
    wait_idle();

    // div=0, all four modes
    for (int m = 0; m < 4; m++) begin
      set_cfg(m[1], m[0], m[0] ^ m[1], 16'd0, 3'd1, 1'b0, m_sl[m]);
      send(m_tx[m], 1'b0, m_sl[m], 1, t);
      check("div0_cs", 32'(cs_n), 32'h1D);
      wait_idle();
    end

    // Reset in the middle of the transfer
    set_cfg(1'b0, 1'b0, 1'b0, 16'd1, 3'd0, 1'b0, 8'h77);
    send(8'h99, 1'b0, 8'h77, 2, t);
    wait_cyc(t + 18);
    cnt_snap = rx_count;
    rst = 1'b1;
    #1;
    check("abort_cs_n", 32'(cs_n), 32'h1F);
    check("abort_sck", 32'(sck), 32'(0));
    check("abort_rx_valid", 32'(rx_valid), 32'(0));
    check("abort_busy", 32'(busy), 32'(0));
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    wait_cyc(t + 40);
    check("abort_no_rx", rx_count, cnt_snap);
    set_cfg(1'b0, 1'b0, 1'b0, 16'd1, 3'd0, 1'b0, 8'h77);
    send(8'h5C, 1'b0, 8'h77, 2, t);
    wait_idle();

    // Out-of-range chip select
    set_cfg(1'b0, 1'b0, 1'b0, 16'd1, 3'd5, 1'b1, 8'h00);
    send(8'h3E, 1'b0, 8'h3E, 2, t);
    check("cs5_none_first", 32'(cs_n), 32'h1F);
    wait_cyc(t + 20);
    check("cs5_none_mid", 32'(cs_n), 32'h1F);
    wait_idle();

    repeat (4) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1, "watchdog");
  end

endmodule
